// File: rtl/alu_op_issue.sv
// ALU operand/control issue slot: decodes an RV32I instruction into an ALU
// control code plus A/B operands and holds them in a one-entry EX slot that
// uses a valid/ready handshake.
module alu_op_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam logic [3:0] AluNop  = 4'h0;
  localparam logic [3:0] AluAdd  = 4'h1;
  localparam logic [3:0] AluSub  = 4'h2;
  localparam logic [3:0] AluAnd  = 4'h3;
  localparam logic [3:0] AluOr   = 4'h4;
  localparam logic [3:0] AluXor  = 4'h5;
  localparam logic [3:0] AluSll  = 4'h6;
  localparam logic [3:0] AluSrl  = 4'h7;
  localparam logic [3:0] AluSlt  = 4'h8;
  localparam logic [3:0] AluSltu = 4'h9;
  localparam logic [3:0] AluSra  = 4'hA;
  localparam logic [3:0] AluAp4  = 4'hB;
  localparam logic [3:0] AluBout = 4'hC;

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic [11:0]     imm_s12;
  logic [31:0]     imm_u32;

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_ctrl;
  logic            dec_ill;

  logic            valid_q;
  logic            ill_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [3:0]      ctrl_q;

  logic capture;
  logic consume;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign imm_s12 = {inst[31:25], inst[11:7]};
  assign imm_u32 = {inst[31:12], 12'b0};

  // Size casts of signed values sign-extend to XLEN.
  assign imm_i = XLEN'(signed'(inst[31:20]));
  assign imm_s = XLEN'(signed'(imm_s12));
  assign imm_u = XLEN'(signed'(imm_u32));
  assign shamt = XLEN'(inst[24:20]);

  // Pure instruction decode into operands, control code and illegal flag.
  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_ctrl = AluNop;
    dec_ill  = 1'b0;
    case (opcode)
      OpcReg: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        if (funct7 == F7Base) begin
          case (funct3)
            3'b000:  dec_ctrl = AluAdd;
            3'b001:  dec_ctrl = AluSll;
            3'b010:  dec_ctrl = AluSlt;
            3'b011:  dec_ctrl = AluSltu;
            3'b100:  dec_ctrl = AluXor;
            3'b101:  dec_ctrl = AluSrl;
            3'b110:  dec_ctrl = AluOr;
            default: dec_ctrl = AluAnd;
          endcase
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          dec_ctrl = AluSub;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          dec_ctrl = AluSra;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OpcImm: begin
        dec_a = rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_ctrl = AluAdd;
          3'b001: begin
            // Shift-immediates carry only the 5-bit shamt as operand B.
            dec_b = shamt;
            if (funct7 == F7Base) dec_ctrl = AluSll;
            else                  dec_ill  = 1'b1;
          end
          3'b010: dec_ctrl = AluSlt;
          3'b011: dec_ctrl = AluSltu;
          3'b100: dec_ctrl = AluXor;
          3'b101: begin
            dec_b = shamt;
            if (funct7 == F7Base)     dec_ctrl = AluSrl;
            else if (funct7 == F7Alt) dec_ctrl = AluSra;
            else                      dec_ill  = 1'b1;
          end
          3'b110:  dec_ctrl = AluOr;
          default: dec_ctrl = AluAnd;
        endcase
      end
      OpcLui: begin
        dec_b    = imm_u;
        dec_ctrl = AluBout;
      end
      OpcAuipc: begin
        dec_a    = pc;
        dec_b    = imm_u;
        dec_ctrl = AluAdd;
      end
      OpcJal, OpcJalr: begin
        dec_a    = pc;
        dec_ctrl = AluAp4;
      end
      OpcLoad: begin
        dec_a    = rs1_data;
        dec_b    = imm_i;
        dec_ctrl = AluAdd;
      end
      OpcStore: begin
        dec_a    = rs1_data;
        dec_b    = imm_s;
        dec_ctrl = AluAdd;
      end
      OpcBranch: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        case (funct3)
          3'b000, 3'b001: dec_ctrl = AluSub;
          3'b100, 3'b101: dec_ctrl = AluSlt;
          3'b110, 3'b111: dec_ctrl = AluSltu;
          default:        dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal entries present all-zero operands and a NOP code.
    if (dec_ill) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_ctrl = AluNop;
    end
  end

  assign in_ready = ~valid_q | out_ready;
  assign capture  = in_valid & in_ready;
  assign consume  = valid_q & out_ready;

  // Slot register: flush beats capture, capture beats a plain consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= AluNop;
    end else if (flush) begin
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      ill_q   <= dec_ill;
      a_q     <= dec_a;
      b_q     <= dec_b;
      ctrl_q  <= dec_ctrl;
    end else if (consume) begin
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign illegal   = ill_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = ctrl_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: hand-computed vector table, stall/flush/reset
// sequences, and randomized traffic against a reference model of the slot.
module tb_alu_op_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic        illegal;

  alu_op_issue #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        ill;
  } ref_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_ctrl;
    logic        exp_ill;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the held entry.
  logic m_valid;
  ref_t m_ent;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA rules using shifts/masks and lookup tables.
  function automatic ref_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
    ref_t r;
    logic [3:0] r_tab[8];
    logic [3:0] br_tab[8];
    logic [31:0] imm_i, imm_s, imm_u, sh;
    int f3, f7, opc;
    r_tab  = '{4'h1, 4'h6, 4'h8, 4'h9, 4'h5, 4'h7, 4'h4, 4'h3};
    br_tab = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h8, 4'h8, 4'h9, 4'h9};
    opc   = int'(i & 32'h7F);
    f3    = int'((i >> 12) & 32'h7);
    f7    = int'(i >> 25);
    imm_i = 32'($signed(i) >>> 20);
    imm_s = 32'(($signed(i) >>> 25) << 5) | ((i >> 7) & 32'h1F);
    imm_u = i & 32'hFFFF_F000;
    sh    = (i >> 20) & 32'h1F;
    r = '{a: 32'h0, b: 32'h0, ctrl: 4'h0, ill: 1'b0};
    case (opc)
      'h33: begin
        r.a = r1; r.b = r2;
        if (f7 == 0) r.ctrl = r_tab[f3];
        else if (f7 == 'h20 && f3 == 0) r.ctrl = 4'h2;
        else if (f7 == 'h20 && f3 == 5) r.ctrl = 4'hA;
        else r.ill = 1'b1;
      end
      'h13: begin
        r.a = r1; r.b = imm_i; r.ctrl = r_tab[f3];
        if (f3 == 1 || f3 == 5) begin
          r.b = sh;
          if (f3 == 5 && f7 == 'h20) r.ctrl = 4'hA;
          else if (f7 != 0) r.ill = 1'b1;
        end
      end
      'h37: begin r.b = imm_u; r.ctrl = 4'hC; end
      'h17: begin r.a = p; r.b = imm_u; r.ctrl = 4'h1; end
      'h6F, 'h67: begin r.a = p; r.ctrl = 4'hB; end
      'h03: begin r.a = r1; r.b = imm_i; r.ctrl = 4'h1; end
      'h23: begin r.a = r1; r.b = imm_s; r.ctrl = 4'h1; end
      'h63: begin
        r.a = r1; r.b = r2; r.ctrl = br_tab[f3];
        if (f3 == 2 || f3 == 3) r.ill = 1'b1;
      end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) r = '{a: 32'h0, b: 32'h0, ctrl: 4'h0, ill: 1'b1};
    return r;
  endfunction

  // One clock: check in_ready, advance the model from current inputs, then
  // compare the registered outputs just after the edge.
  task automatic tick();
    logic nv;
    ref_t ne;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    nv = m_valid;
    ne = m_ent;
    if (flush) begin
      nv = 1'b0;
      ne.ill = 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      nv = 1'b1;
      ne = ref_decode(inst, pc, rs1_data, rs2_data);
    end else if (m_valid && out_ready) begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = nv;
    m_ent   = ne;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("alu_a", alu_a, m_ent.a);
      check("alu_b", alu_b, m_ent.b);
      check("alu_ctrl", 32'(alu_ctrl), 32'(m_ent.ctrl));
      check("illegal", 32'(illegal), 32'(m_ent.ill));
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                       input logic [31:0] r2, input logic iv, input logic ordy, input logic fl);
    inst = i; pc = p; rs1_data = r1; rs2_data = r2;
    in_valid = iv; out_ready = ordy; flush = fl;
  endtask

  logic [6:0] opc_pool[10];
  vec_t vecs[15];

  initial begin
    opc_pool = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F};
    vecs[0]  = '{"add",    32'h002081B3, 32'h0,   32'h5,        32'h7, 32'h5,        32'h7,        4'h1, 1'b0};
    vecs[1]  = '{"sub",    32'h402081B3, 32'h0,   32'hA,        32'h3, 32'hA,        32'h3,        4'h2, 1'b0};
    vecs[2]  = '{"srai",   32'h40335293, 32'h0,   32'h8000_0000, 32'h9, 32'h8000_0000, 32'h3,       4'hA, 1'b0};
    vecs[3]  = '{"lui",    32'h123450B7, 32'h0,   32'h11,       32'h22, 32'h0,       32'h1234_5000, 4'hC, 1'b0};
    vecs[4]  = '{"jal",    32'h008000EF, 32'h100, 32'h11,       32'h22, 32'h100,     32'h0,        4'hB, 1'b0};
    vecs[5]  = '{"ones",   32'hFFFF_FFFF, 32'h40, 32'h11,       32'h22, 32'h0,       32'h0,        4'h0, 1'b1};
    vecs[6]  = '{"slli7",  32'h40109093, 32'h0,   32'h11,       32'h22, 32'h0,       32'h0,        4'h0, 1'b1};
    vecs[7]  = '{"addi-1", 32'hFFF00093, 32'h0,   32'h10,       32'h22, 32'h10,      32'hFFFF_FFFF, 4'h1, 1'b0};
    vecs[8]  = '{"sw-4",   32'hFE20AE23, 32'h0,   32'h1000,     32'h22, 32'h1000,    32'hFFFF_FFFC, 4'h1, 1'b0};
    vecs[9]  = '{"bltu",   32'h0020E063, 32'h0,   32'h3,        32'h4, 32'h3,        32'h4,        4'h9, 1'b0};
    vecs[10] = '{"br010",  32'h0020A063, 32'h0,   32'h3,        32'h4, 32'h0,        32'h0,        4'h0, 1'b1};
    vecs[11] = '{"auipc",  32'h80000097, 32'h200, 32'h3,        32'h4, 32'h200,      32'h8000_0000, 4'h1, 1'b0};
    vecs[12] = '{"mul",    32'h022081B3, 32'h0,   32'h3,        32'h4, 32'h0,        32'h0,        4'h0, 1'b1};
    vecs[13] = '{"sra",    32'h4020D1B3, 32'h0,   32'hF0,       32'h4, 32'hF0,       32'h4,        4'hA, 1'b0};
    vecs[14] = '{"lw",     32'h0080A183, 32'h0,   32'h2000,     32'h4, 32'h2000,     32'h8,        4'h1, 1'b0};

    m_valid = 1'b0;
    m_ent   = '{a: 32'h0, b: 32'h0, ctrl: 4'h0, ill: 1'b0};
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #12;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst illegal", 32'(illegal), 32'h0);
    check("rst alu_a", alu_a, 32'h0);
    check("rst alu_b", alu_b, 32'h0);
    check("rst alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back table vectors with out_ready held high.
    foreach (vecs[k]) begin
      drive(vecs[k].inst, vecs[k].pc, vecs[k].rs1, vecs[k].rs2, 1'b1, 1'b1, 1'b0);
      tick();
      check({vecs[k].name, " valid"}, 32'(out_valid), 32'h1);
      check({vecs[k].name, " a"}, alu_a, vecs[k].exp_a);
      check({vecs[k].name, " b"}, alu_b, vecs[k].exp_b);
      check({vecs[k].name, " ctrl"}, 32'(alu_ctrl), 32'(vecs[k].exp_ctrl));
      check({vecs[k].name, " ill"}, 32'(illegal), 32'(vecs[k].exp_ill));
    end

    // Stall: hold an add for 3 cycles while a sub waits, then release.
    drive(32'h002081B3, 32'h0, 32'h5, 32'h7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h402081B3, 32'h0, 32'h50, 32'h7, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall in_ready", 32'(in_ready), 32'h0);
      check("stall ctrl", 32'(alu_ctrl), 32'h1);
      check("stall a", alu_a, 32'h5);
    end
    out_ready = 1'b1;
    tick();
    check("release valid", 32'(out_valid), 32'h1);
    check("release ctrl", 32'(alu_ctrl), 32'h2);
    check("release a", alu_a, 32'h50);

    // Flush while an illegal entry is held and a capture is attempted.
    drive(32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h002081B3, 32'h0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
    tick();
    check("held illegal", 32'(illegal), 32'h1);
    drive(32'h002081B3, 32'h0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1);
    tick();
    check("flush valid", 32'(out_valid), 32'h0);
    check("flush illegal", 32'(illegal), 32'h0);
    flush = 1'b0;

    // Asynchronous reset in the middle of a stall.
    drive(32'h0080A183, 32'h0, 32'h2000, 32'h4, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h0080A183, 32'h0, 32'h2000, 32'h4, 1'b1, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async valid", 32'(out_valid), 32'h0);
    check("async a", alu_a, 32'h0);
    check("async b", alu_b, 32'h0);
    check("async ctrl", 32'(alu_ctrl), 32'h0);
    m_valid = 1'b0;
    m_ent   = '{a: 32'h0, b: 32'h0, ctrl: 4'h0, ill: 1'b0};
    #2;
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ri;
      ri = $urandom;
      if ($urandom_range(0, 9) != 0) ri[6:0] = opc_pool[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0: ri[31:25] = 7'h00;
        1: ri[31:25] = 7'h20;
        default: ;
      endcase
      drive(ri, $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
